hazard_pattern_decoder: RTL

- Observes the 3-bit hazard-light frame stream driven onto the runway lights and recovers the wind-mode code that produced it.
- Each sample strobe captures one frame. Consecutive frame pairs are classified, and the block locks onto a mode after a configurable run of consistent transitions.
- Sits on the monitor/self-check side of the lights path. It feeds LED/status indicators and the board-level checker.

---
 rtl/hazard_pkg.sv | 50 +++++
 rtl/hazard_pattern_decoder_if.sv | 22 ++
 rtl/hazard_transition_classifier.sv | 31 +++
 rtl/hazard_pattern_decoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard-light pattern decoder: mode codes, frame
// constants, transition classes, decoder states and small helpers.
package hazard_pkg;

    typedef enum logic [1:0] {
        MODE_CALM = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam logic [2:0] PAT_A = 3'b101;
    localparam logic [2:0] PAT_B = 3'b001;
    localparam logic [2:0] PAT_C = 3'b010;
    localparam logic [2:0] PAT_D = 3'b100;

    typedef enum logic [2:0] {
        CALM,
        UP,
        DOWN,
        HOLD,
        NEUTRAL,
        ILLEGAL
    } tclass_t;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        LOCKED
    } dec_state_t;

    function automatic logic frame_legal(input logic [2:0] f);
        return (f == PAT_A) || (f == PAT_B) ||
               (f == PAT_C) || (f == PAT_D);
    endfunction

    // Only meaningful for CALM/UP/DOWN/HOLD.
    function automatic mode_t class_to_mode(input tclass_t c);
        mode_t m;
        m = MODE_CALM;
        unique case (c)
            UP:      m = MODE_UP;
            DOWN:    m = MODE_DOWN;
            HOLD:    m = MODE_HOLD;
            default: m = MODE_CALM;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hazard_pattern_decoder_if.sv
// Frame-in / status-out bundle of the hazard pattern decoder.
// master: frame source + status consumer; slave: the decoder.
interface hazard_pattern_decoder_if #(
    parameter int ERR_W = 8
);
    logic             sample;
    logic [2:0]       lights;
    logic [1:0]       mode;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample, lights,
        input  mode, locked, err, err_count
    );

    modport slave (
        input  sample, lights,
        output mode, locked, err, err_count
    );
endinterface

// File: rtl/hazard_transition_classifier.sv
// Combinational classifier of a (prev, cur) light-frame pair.
// Ports: prev[2:0], cur[2:0] in; tclass (tclass_t) out.
module hazard_transition_classifier
    import hazard_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] cur,
    output tclass_t    tclass
);

    always_comb begin
        tclass = ILLEGAL;
        unique case ({prev, cur})
            {PAT_A, PAT_C}: tclass = CALM;
            {PAT_C, PAT_A}: tclass = CALM;
            {PAT_B, PAT_C}: tclass = UP;
            {PAT_C, PAT_D}: tclass = UP;
            {PAT_D, PAT_B}: tclass = UP;
            {PAT_D, PAT_C}: tclass = DOWN;
            {PAT_C, PAT_B}: tclass = DOWN;
            {PAT_B, PAT_D}: tclass = DOWN;
            {PAT_A, PAT_A}: tclass = HOLD;
            {PAT_A, PAT_B}: tclass = NEUTRAL;
            {PAT_A, PAT_D}: tclass = NEUTRAL;
            {PAT_B, PAT_A}: tclass = NEUTRAL;
            {PAT_D, PAT_A}: tclass = NEUTRAL;
            default:        tclass = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/hazard_pattern_decoder.sv
// Recovers the wind-mode code from the sampled hazard-light frame stream.
// Ports: clk, reset (sync, active-high), bus (slave: sample, lights in;
// mode, locked, err, err_count out).
module hazard_pattern_decoder
    import hazard_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_pattern_decoder_if.slave bus
);

    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam logic [RW-1:0] LC_R  = RW'(LOCK_COUNT);
    localparam logic [RW-1:0] ONE_R = RW'(1);

    logic [2:0]       prev, prev_n;
    logic             prev_valid, prev_valid_n;
    dec_state_t       state, state_n;
    logic [RW-1:0]    run, run_n;
    logic [RW-1:0]    run_inc;
    mode_t            cand, cand_n;
    mode_t            mode, mode_n;
    mode_t            cls_mode;
    logic             err, err_n;
    logic [ERR_W-1:0] err_cnt, err_cnt_n;
    logic             illegal;
    tclass_t          tclass;

    hazard_transition_classifier u_cls (
        .prev   (prev),
        .cur    (bus.lights),
        .tclass (tclass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 3'b000;
            prev_valid <= 1'b0;
            state      <= IDLE;
            run        <= '0;
            cand       <= MODE_CALM;
            mode       <= MODE_CALM;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            prev       <= prev_n;
            prev_valid <= prev_valid_n;
            state      <= state_n;
            run        <= run_n;
            cand       <= cand_n;
            mode       <= mode_n;
            err        <= err_n;
            err_cnt    <= err_cnt_n;
        end
    end

    always_comb begin
        prev_n       = prev;
        prev_valid_n = prev_valid;
        state_n      = state;
        run_n        = run;
        cand_n       = cand;
        mode_n       = mode;
        err_n        = 1'b0;
        err_cnt_n    = err_cnt;
        illegal      = 1'b0;
        run_inc      = run + ONE_R;
        cls_mode     = class_to_mode(tclass);

        if (bus.sample) begin
            if (!prev_valid) begin
                // First frame after reset/error only seeds prev.
                if (frame_legal(bus.lights)) begin
                    prev_n       = bus.lights;
                    prev_valid_n = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end else begin
                prev_n = bus.lights;
                unique case (tclass)
                    ILLEGAL: illegal = 1'b1;
                    NEUTRAL: begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                    default: begin
                        if (state != IDLE && cls_mode == cand) begin
                            // LOCKED + same class: nothing moves.
                            if (state == CAND) begin
                                run_n = run_inc;
                                if (run_inc == LC_R) begin
                                    state_n = LOCKED;
                                    mode_n  = cand;
                                end
                            end
                        end else begin
                            cand_n = cls_mode;
                            run_n  = ONE_R;
                            if (ONE_R == LC_R) begin
                                state_n = LOCKED;
                                mode_n  = cls_mode;
                            end else begin
                                state_n = CAND;
                            end
                        end
                    end
                endcase
            end

            if (illegal) begin
                err_n        = 1'b1;
                state_n      = IDLE;
                run_n        = '0;
                prev_valid_n = 1'b0;
                if (err_cnt != {ERR_W{1'b1}})
                    err_cnt_n = err_cnt + ERR_W'(1);
            end
        end
    end

    assign bus.mode      = mode;
    assign bus.locked    = (state == LOCKED);
    assign bus.err       = err;
    assign bus.err_count = err_cnt;

endmodule
